// File: rtl/tcm_boot_loader_pkg.sv
// tcm_boot_loader_pkg: shared constants and the frame FSM state encoding
// for the TCM boot-image loader.
package tcm_boot_loader_pkg;

    localparam int TCM_BYTES = 131072;
    localparam int HDR_BYTES = 4;

    typedef enum logic [1:0] {
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DONE
    } state_t;

endpackage

// File: rtl/tcm_word_packer.sv
// tcm_word_packer: packs payload bytes into a 64-bit word with a byte-lane
// mask and emits it as a one-cycle registered write.
// Ports: clk_i, rst_i (async, active-low); byte_valid_i/byte_i/lane_i
//        insert a byte; lane_en_i sets the lane strobe; emit_i flushes
//        the word; data_o/wr_o are the registered write data and strobes.
module tcm_word_packer
    import tcm_boot_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic [2:0]  lane_i,
    input  logic        lane_en_i,
    input  logic        emit_i,
    output logic [63:0] data_o,
    output logic [7:0]  wr_o
);

    logic [63:0] pack_q, pack_d;
    logic [7:0]  mask_q, mask_d;

    // Out-of-range bytes are consumed without touching data or mask.
    always_comb begin
        pack_d = pack_q;
        mask_d = mask_q;
        if (lane_en_i) begin
            pack_d[{lane_i, 3'b000} +: 8] = byte_i;
            mask_d[lane_i]                = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pack_q <= '0;
            mask_q <= '0;
            data_o <= '0;
            wr_o   <= '0;
        end else begin
            wr_o <= '0;
            if (byte_valid_i) begin
                if (emit_i) begin
                    data_o <= pack_d;
                    wr_o   <= mask_d;
                    pack_q <= '0;
                    mask_q <= '0;
                end else begin
                    pack_q <= pack_d;
                    mask_q <= mask_d;
                end
            end
        end
    end

endmodule

// File: rtl/tcm_boot_loader.sv
// tcm_boot_loader: parses framed segments (addr, len, payload) from a byte
// stream, writes them into the TCM and releases core reset on a terminator.
// Ports: clk_i, rst_i (async, active-low); in_valid_i/in_data_i/in_ready_o
//        byte stream; tcm_addr_o/tcm_data_o/tcm_wr_o RAM write port;
//        core_reset_o, err_o, checksum_o (TCM_BOOT_LOADER_CSUM_EN).
module tcm_boot_loader
    import tcm_boot_loader_pkg::*;
#(
    parameter int TCM_AW = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic [TCM_AW-1:0] tcm_addr_o,
    output logic [63:0]       tcm_data_o,
    output logic [7:0]        tcm_wr_o,
    output logic              core_reset_o,
    output logic              err_o,
    output logic [31:0]       checksum_o
);

    state_t      state_q, state_d;
    logic [1:0]  hdr_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic [31:0] len_nxt;
    logic        accept;
    logic        hdr_last;
    logic        data_acc;
    logic        in_range;
    logic        emit;

    assign accept   = in_valid_i && in_ready_o;
    assign hdr_last = (hdr_cnt_q == 2'(HDR_BYTES - 1));
    assign len_nxt  = {in_data_i, len_q[31:8]};
    assign data_acc = accept && (state_q == S_DATA);
    // Wrapped addresses fall back to small values only after passing
    // 0xFFFFFFFF, so a plain compare covers the whole 32-bit space.
    assign in_range = (addr_q < 32'(TCM_BYTES));
    assign emit     = (addr_q[2:0] == 3'd7) || (len_q == 32'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ADDR: if (accept && hdr_last) state_d = S_LEN;
            S_LEN: begin
                if (accept && hdr_last)
                    state_d = (len_nxt == 32'd0) ? S_DONE : S_DATA;
            end
            S_DATA: if (accept && len_q == 32'd1) state_d = S_ADDR;
            S_DONE: state_d = S_DONE;
            default: state_d = S_ADDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_ADDR;
        else        state_q <= state_d;
    end

    // Header bytes are little-endian: shift in from the top so the first
    // byte ends up in bits [7:0] after four bytes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hdr_cnt_q    <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            in_ready_o   <= 1'b0;
            core_reset_o <= 1'b1;
            err_o        <= 1'b0;
            tcm_addr_o   <= '0;
        end else begin
            in_ready_o   <= (state_d != S_DONE);
            core_reset_o <= (state_d != S_DONE);
            if (accept) begin
                unique case (state_q)
                    S_ADDR: begin
                        addr_q    <= {in_data_i, addr_q[31:8]};
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                    end
                    S_LEN: begin
                        len_q     <= len_nxt;
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                    end
                    S_DATA: begin
                        addr_q    <= addr_q + 32'd1;
                        len_q     <= len_q - 32'd1;
                        hdr_cnt_q <= '0;
                        if (!in_range) err_o <= 1'b1;
                        if (emit) tcm_addr_o <= addr_q[TCM_AW+2:3];
                    end
                    default: ;
                endcase
            end
        end
    end

    tcm_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .byte_valid_i(data_acc),
        .byte_i      (in_data_i),
        .lane_i      (addr_q[2:0]),
        .lane_en_i   (in_range),
        .emit_i      (emit),
        .data_o      (tcm_data_o),
        .wr_o        (tcm_wr_o)
    );

`ifdef TCM_BOOT_LOADER_CSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)        csum_q <= '0;
        else if (data_acc) csum_q <= csum_q + {24'd0, in_data_i};
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_tcm_boot_loader.sv
// tb_tcm_boot_loader: directed bench for tcm_boot_loader with a write
// scoreboard; checksum expectations follow TCM_BOOT_LOADER_CSUM_EN.
module tb_tcm_boot_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic [13:0] tcm_addr_o;
    logic [63:0] tcm_data_o;
    logic [7:0]  tcm_wr_o;
    logic        core_reset_o;
    logic        err_o;
    logic [31:0] checksum_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [13:0] a;
        logic [7:0]  m;
        logic [63:0] d;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk_i = ~clk_i;

    tcm_boot_loader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .tcm_addr_o  (tcm_addr_o),
        .tcm_data_o  (tcm_data_o),
        .tcm_wr_o    (tcm_wr_o),
        .core_reset_o(core_reset_o),
        .err_o       (err_o),
        .checksum_o  (checksum_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic push(input logic [13:0] a, input logic [7:0] m,
                        input logic [63:0] d);
        wr_t e;
        e.a = a;
        e.m = m;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid_i = 1'b1;
        in_data_i  = b;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send_w32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Every strobed cycle must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && tcm_wr_o !== 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(tcm_wr_o), 64'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(tcm_addr_o), 64'(e.a));
                chk("wr_mask", 64'(tcm_wr_o), 64'(e.m));
                chk("wr_data", tcm_data_o & lanes(e.m), e.d & lanes(e.m));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] csum_exp;

    initial begin
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        idle(3);
        @(negedge clk_i);
        chk("rst_ready", 64'(in_ready_o), 64'h0);
        chk("rst_wr", 64'(tcm_wr_o), 64'h0);
        chk("rst_addr", 64'(tcm_addr_o), 64'h0);
        chk("rst_data", tcm_data_o, 64'h0);
        chk("rst_core", 64'(core_reset_o), 64'h1);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_csum", 64'(checksum_o), 64'h0);
        rst_i = 1'b1;
        idle(1);
        chk("ready_up", 64'(in_ready_o), 64'h1);

        // Aligned single word.
        push(14'h20, 8'hFF, 64'h8877665544332211);
        send_w32(32'h100);
        send_w32(32'd8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));

        // Unaligned start and end, back-to-back with the previous frame.
        push(14'h1, 8'hE0, 64'hA2A1A00000000000);
        push(14'h2, 8'h03, 64'h000000000000A4A3);
        send_w32(32'h0D);
        send_w32(32'd5);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));

        // Straddles the top of the TCM.
        push(14'h3FFF, 8'hC0, 64'hB1B0000000000000);
        send_w32(32'h1FFFE);
        send_w32(32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
        idle(2);
        chk("err_set", 64'(err_o), 64'h1);
        chk("core_held", 64'(core_reset_o), 64'h1);

        // Reset after three payload bytes: partial word dropped.
        send_w32(32'h0);
        send_w32(32'd8);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        rst_i = 1'b0;
        idle(2);
        chk("midrst_wr", 64'(tcm_wr_o), 64'h0);
        chk("midrst_err", 64'(err_o), 64'h0);
        rst_i = 1'b1;
        idle(1);
        push(14'h8, 8'h03, 64'h0000000000005B5A);
        send_w32(32'h40);
        send_w32(32'd2);
        send_byte(8'h5A);
        send_byte(8'h5B);
        idle(2);
        chk("fresh_err", 64'(err_o), 64'h0);
        chk("sb_after_fresh", 64'(exp_q.size()), 64'h0);

        // Clean restart, then 300 x 0xFF and the terminator.
        rst_i = 1'b0;
        idle(2);
        rst_i = 1'b1;
        idle(1);
        for (int i = 0; i < 37; i++) push(14'h200 + 14'(i), 8'hFF, '1);
        push(14'h225, 8'h0F, 64'h00000000FFFFFFFF);
        send_w32(32'h1000);
        send_w32(32'd300);
        for (int i = 0; i < 300; i++) send_byte(8'hFF);
`ifdef TCM_BOOT_LOADER_CSUM_EN
        csum_exp = 32'h00012AD4;
`else
        csum_exp = 32'h0;
`endif
        chk("csum", 64'(checksum_o), 64'(csum_exp));
        send_w32(32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        chk("core_before_term", 64'(core_reset_o), 64'h1);
        chk("ready_before_term", 64'(in_ready_o), 64'h1);
        send_byte(8'h00);
        chk("core_released", 64'(core_reset_o), 64'h0);
        chk("ready_done", 64'(in_ready_o), 64'h0);

        // Bytes offered in S_DONE are ignored.
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        idle(6);
        in_valid_i = 1'b0;
        idle(2);
        chk("csum_hold", 64'(checksum_o), 64'(csum_exp));
        chk("core_stays", 64'(core_reset_o), 64'h0);
        chk("ready_stays", 64'(in_ready_o), 64'h0);
        chk("sb_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
